// File: rtl/arb_req_tracker.sv
// Turns per-client request pulses into level requests held until granted, for rr_arbiter.
// Optional starvation watchdog (wait counters + starve_err) under `ARB_REQ_STARVE_CHK_EN.
module arb_req_tracker #(
    parameter int CLIENTS = 32,
    parameter int CNT_W   = 4,
    parameter int IDX_W   = $clog2(CLIENTS)
`ifdef ARB_REQ_STARVE_CHK_EN
    , parameter int STARVE_LIMIT = 2 * CLIENTS
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CLIENTS-1:0] req_pulse,
    input  logic [CLIENTS-1:0] grant,
    output logic [CLIENTS-1:0] request,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               pending_any,
    output logic [CLIENTS-1:0] overflow,
    output logic               spurious_gnt,
    output logic               multi_gnt
`ifdef ARB_REQ_STARVE_CHK_EN
    , output logic             starve_err
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]   cnt     [CLIENTS];
    logic [CNT_W-1:0]   cnt_nxt [CLIENTS];
    logic [CLIENTS-1:0] sat;
    logic [CLIENTS-1:0] inc;
    logic [CLIENTS-1:0] dec;
    logic [CLIENTS-1:0] pulse_drop;
    logic [IDX_W:0]     gnt_pop;
    logic [IDX_W-1:0]   gnt_enc;
    logic               gnt_legal;

    always_comb begin
        for (int i = 0; i < CLIENTS; i++) begin
            request[i] = (cnt[i] != '0);
            sat[i]     = (cnt[i] == CNT_MAX);
        end
    end

    assign pending_any = |request;
    // A grant frees a slot in the same cycle, so a pulse at saturation is kept when paired with a grant.
    assign dec        = grant & request;
    assign inc        = req_pulse & (~sat | dec);
    assign pulse_drop = req_pulse & ~inc;

    always_comb begin
        for (int i = 0; i < CLIENTS; i++) begin
            cnt_nxt[i] = cnt[i];
            case ({inc[i], dec[i]})
                2'b10:   cnt_nxt[i] = cnt[i] + CNT_W'(1);
                2'b01:   cnt_nxt[i] = cnt[i] - CNT_W'(1);
                default: cnt_nxt[i] = cnt[i];
            endcase
        end
    end

    always_comb begin
        gnt_pop = '0;
        gnt_enc = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            gnt_pop = gnt_pop + {{IDX_W{1'b0}}, grant[i]};
            if (grant[i]) gnt_enc = IDX_W'(i);
        end
        gnt_legal = (gnt_pop == (IDX_W+1)'(1)) && (|dec);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CLIENTS; i++) cnt[i] <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            overflow     <= '0;
            spurious_gnt <= 1'b0;
            multi_gnt    <= 1'b0;
        end else begin
            for (int i = 0; i < CLIENTS; i++) cnt[i] <= cnt_nxt[i];
            grant_valid  <= gnt_legal;
            if (gnt_legal) grant_idx <= gnt_enc;
            overflow     <= overflow | pulse_drop;
            spurious_gnt <= spurious_gnt | (|(grant & ~request));
            multi_gnt    <= multi_gnt | (gnt_pop > (IDX_W+1)'(1));
        end
    end

`ifdef ARB_REQ_STARVE_CHK_EN
    localparam int              WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0]  wait_cnt [CLIENTS];
    logic [CLIENTS-1:0] at_limit;

    always_comb begin
        for (int i = 0; i < CLIENTS; i++) at_limit[i] = (wait_cnt[i] == WAIT_MAX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CLIENTS; i++) wait_cnt[i] <= '0;
            starve_err <= 1'b0;
        end else begin
            for (int i = 0; i < CLIENTS; i++) begin
                if (!request[i] || grant[i])
                    wait_cnt[i] <= '0;
                else if (!at_limit[i])
                    wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
            end
            starve_err <= starve_err | (|at_limit);
        end
    end
`endif

endmodule

// File: tb/tb_arb_req_tracker.sv
// Directed + random bench for arb_req_tracker against a count-per-client reference model.
module tb_arb_req_tracker;
    localparam int N    = 32;
    localparam int MAXC = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_pulse = '0;
    logic [N-1:0]  grant = '0;
    logic [N-1:0]  request;
    logic          grant_valid;
    logic [4:0]    grant_idx;
    logic          pending_any;
    logic [N-1:0]  overflow;
    logic          spurious_gnt;
    logic          multi_gnt;

    int            n_vec = 0;
    int            n_err = 0;

    int            mcnt [N];
    logic [N-1:0]  m_ovf;
    logic          m_spur, m_multi, m_gv;
    int            m_idx;

    arb_req_tracker #(.CLIENTS(N), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .req_pulse(req_pulse), .grant(grant),
        .request(request), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .pending_any(pending_any), .overflow(overflow),
        .spurious_gnt(spurious_gnt), .multi_gnt(multi_gnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        m_ovf = '0; m_spur = 0; m_multi = 0; m_gv = 0; m_idx = 0;
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] er;
        er = '0;
        for (int i = 0; i < N; i++) er[i] = (mcnt[i] > 0);
        chk({tag, ".request"},  64'(request),      64'(er));
        chk({tag, ".pending"},  64'(pending_any),  64'(|er));
        chk({tag, ".gvalid"},   64'(grant_valid),  64'(m_gv));
        chk({tag, ".gidx"},     64'(grant_idx),    64'(m_idx));
        chk({tag, ".overflow"}, 64'(overflow),     64'(m_ovf));
        chk({tag, ".spurious"}, 64'(spurious_gnt), 64'(m_spur));
        chk({tag, ".multi"},    64'(multi_gnt),    64'(m_multi));
    endtask

    // One clock: drive at negedge, advance the model at posedge, check 1 time unit later.
    task automatic step(input string tag, input logic [N-1:0] p, input logic [N-1:0] g);
        int pop, gi;
        bit d, n;
        req_pulse = p;
        grant     = g;
        @(posedge clock);
        pop = $countones(g);
        gi  = 0;
        for (int i = 0; i < N; i++) if (g[i]) gi = i;
        m_gv = (pop == 1) && (mcnt[gi] > 0);
        if (m_gv) m_idx = gi;
        if (pop > 1) m_multi = 1;
        for (int i = 0; i < N; i++) begin
            d = g[i] && (mcnt[i] > 0);
            if (g[i] && mcnt[i] == 0) m_spur = 1;
            n = p[i] && ((mcnt[i] < MAXC) || d);
            if (p[i] && !n) m_ovf[i] = 1'b1;
            mcnt[i] = mcnt[i] + int'(n) - int'(d);
        end
        #1;
        check_all(tag);
        @(negedge clock);
        req_pulse = '0;
        grant     = '0;
    endtask

    task automatic do_reset();
        req_pulse = '0;
        grant     = '0;
        #1 reset = 1'b1;
        model_reset();
        #1 check_all("reset");
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] p, g;
        int r, s;
        model_reset();
        #2 check_all("por");
        @(negedge clock);
        reset = 1'b0;

        // Single pulse held for 100 cycles
        step("pulse4", 32'h10, '0);
        for (int k = 0; k < 100; k++) step("hold4", '0, '0);
        chk("hold4.req", 64'(request[4]), 64'd1);

        // Three pulses, three spaced grants
        do_reset();
        for (int k = 0; k < 3; k++) step("p3x4", 32'h10, '0);
        for (int k = 0; k < 3; k++) begin
            step("g4", '0, 32'h10);
            chk("g4.gidx", 64'(grant_idx), 64'd4);
            step("g4idle", '0, '0);
        end
        chk("g4.done", 64'(request[4]), 64'd0);

        // Saturation of client 0
        do_reset();
        for (int k = 0; k < 16; k++) step("sat0", 32'h1, '0);
        chk("sat0.ovf", 64'(overflow[0]), 64'd1);
        step("satpg", 32'h1, 32'h1);
        for (int k = 0; k < 15; k++) step("drain0", '0, 32'h1);
        chk("drain0.req", 64'(request[0]), 64'd0);

        // Spurious grant, then multi-grant
        do_reset();
        step("spur7", '0, 32'h80);
        step("p0p4", 32'h11, '0);
        step("p0p4b", 32'h11, '0);
        step("multi", '0, 32'h11);
        chk("multi.flag", 64'(multi_gnt), 64'd1);
        step("multi2", '0, '0);

        // Simultaneous pulse+grant, then async reset mid-stream
        do_reset();
        step("p2a", 32'h4, '0);
        step("p2b", 32'h4, '0);
        step("pg2", 32'h4, 32'h4);
        step("pg2b", 32'h4, 32'h4);
        step("pg2c", 32'h5, '0);
        #2 reset = 1'b1;
        #1 chk("midrst.req", 64'(request), 64'd0);
        model_reset();
        check_all("midrst");
        @(negedge clock);
        reset = 1'b0;

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            p = ($urandom_range(0, 1) == 0) ? '0 : ($urandom & $urandom & $urandom & $urandom);
            r = $urandom_range(0, 9);
            g = '0;
            if (r <= 5) begin
                s = $urandom_range(0, N - 1);
                for (int j = 0; j < N; j++)
                    if (g == '0 && mcnt[(s + j) % N] > 0) g[(s + j) % N] = 1'b1;
            end else if (r == 6) begin
                g[$urandom_range(0, N - 1)] = 1'b1;
            end else if (r == 7) begin
                g[$urandom_range(0, N - 1)] = 1'b1;
                g[$urandom_range(0, N - 1)] = 1'b1;
            end
            step("rand", p, g);
            if (k == 1500) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
